// File: rtl/selector_sequencer.sv
// Sequencer for the K-lane window selector array: walks base+step*stride addresses, captures results.
// Build option SEL_SEQ_CLAMP_EN: lane addresses saturate at SIZE-1 instead of wrapping.
module selector_sequencer #(
    parameter int SIZE   = 16,
    parameter int K      = 4,
    parameter int STEP_W = 8,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW-1:0]     stride,
    input  logic [STEP_W-1:0] num_steps,
    output logic [AW*K-1:0]   N_flat,
    input  logic [K*K-1:0]    sel_result,
    output logic [K*K-1:0]    out_data,
    output logic [STEP_W-1:0] out_step,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int AW1 = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] nsteps_q, nsteps_d;
    logic [AW-1:0]     stride_q, stride_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW*K-1:0]   n_flat_q, n_flat_d;
    logic [K*K-1:0]    data_q, data_d;
    logic [STEP_W-1:0] ostep_q, ostep_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;

    logic              cap;
    logic              is_last;
    logic [AW-1:0]     nb;

    function automatic logic [AW*K-1:0] lane_addrs(input logic [AW-1:0] b);
        logic [AW*K-1:0] a;
`ifdef SEL_SEQ_CLAMP_EN
        logic [AW:0] s;
`endif
        a = '0;
        for (int i = 0; i < K; i++) begin
`ifdef SEL_SEQ_CLAMP_EN
            s = {1'b0, b} + AW1'(i);
            a[i*AW +: AW] = (s > AW1'(SIZE - 1)) ? AW'(SIZE - 1) : s[AW-1:0];
`else
            a[i*AW +: AW] = b + AW'(i);
`endif
        end
        return a;
    endfunction

    // Running base advances by stride each step, so no multiplier is needed.
    function automatic logic [AW-1:0] next_base(input logic [AW-1:0] b,
                                                input logic [AW-1:0] s);
`ifdef SEL_SEQ_CLAMP_EN
        logic [AW:0] t;
        t = {1'b0, b} + {1'b0, s};
        return (t > AW1'(SIZE - 1)) ? AW'(SIZE - 1) : t[AW-1:0];
`else
        return b + s;
`endif
    endfunction

    assign cap     = !valid_q || out_ready;
    assign is_last = (step_q == nsteps_q - STEP_W'(1));
    assign nb      = next_base(base_q, stride_q);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        nsteps_d = nsteps_q;
        stride_d = stride_q;
        base_d   = base_q;
        n_flat_d = n_flat_q;
        data_d   = data_q;
        ostep_d  = ostep_q;
        last_d   = last_q;
        valid_d  = valid_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nsteps_d = num_steps;
                    stride_d = stride;
                    base_d   = base_addr;
                    step_d   = '0;
                    if (num_steps == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RUN;
                        n_flat_d = lane_addrs(base_addr);
                    end
                end
            end
            RUN: begin
                if (cap) begin
                    data_d  = sel_result;
                    ostep_d = step_q;
                    last_d  = is_last;
                    valid_d = 1'b1;
                    if (is_last) begin
                        state_d = DRAIN;
                    end else begin
                        step_d   = step_q + STEP_W'(1);
                        base_d   = nb;
                        n_flat_d = lane_addrs(nb);
                    end
                end
            end
            DRAIN: begin
                if (cap) state_d = DONE;
            end
            DONE: begin
                state_d  = IDLE;
                n_flat_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            nsteps_q <= '0;
            stride_q <= '0;
            base_q   <= '0;
            n_flat_q <= '0;
            data_q   <= '0;
            ostep_q  <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            nsteps_q <= nsteps_d;
            stride_q <= stride_d;
            base_q   <= base_d;
            n_flat_q <= n_flat_d;
            data_q   <= data_d;
            ostep_q  <= ostep_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
        end
    end

    assign N_flat    = n_flat_q;
    assign out_data  = data_q;
    assign out_step  = ostep_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: doc/selector_sequencer.md
Name: selector_sequencer

Overview:
- Controller that drives the address bus of the K-lane window selector array and collects its results.
- On a start command it walks a programmed address sequence: per step, lane i selects at (base + step*stride + i).
- Each step's K*K-bit selector result is captured into a one-entry output register with a valid/ready handshake, so a downstream consumer can apply backpressure.
- The selector array stays purely combinational; this block owns all sequencing and timing.

Parameters:
- SIZE, 16: address range of each selector lane; must be a power of two; AW = $clog2(SIZE).
- K, 4: number of selector lanes; each lane result is K bits.
- STEP_W, 8: width of the step count and step index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request; sampled only in IDLE
- base_addr  in  AW  step-0 address of lane 0; latched on accepted start
- stride  in  AW  address increment per step; latched on accepted start
- num_steps  in  STEP_W  number of steps; latched on accepted start; 0 is legal
- N_flat  out  AW*K  registered lane addresses to the selector array; lane i occupies [i*AW +: AW]
- sel_result  in  K*K  combinational result from the selector array for the current N_flat
- out_data  out  K*K  captured result
- out_step  out  STEP_W  step index of out_data
- out_last  out  1  high with the final step's out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- busy  out  1  high in RUN, DRAIN and DONE
- done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset: state=IDLE; N_flat, out_data, out_step, out_last, out_valid, busy and done are all 0. Reset is asynchronous and may assert in any state; the block returns to IDLE and any pending output is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches the operands.
  - If num_steps=0, go to DONE.
  - Otherwise go to RUN with step=0 and N_flat loaded with the step-0 addresses.
- Address rule: lane i address = (base + step*stride + i) mod SIZE, i.e. truncation to AW bits. Compute it from a registered running base, not a multiplier.
- RUN capture:
  - Capture condition: out_valid==0 || out_ready==1.
  - On capture: out_data<=sel_result, out_step<=step, out_last<=(step==num_steps-1), out_valid<=1.
  - If that was not the last step: step++ and N_flat advances to the next step's addresses in the same edge.
  - If it was the last step: go to DRAIN. N_flat holds its value.
  - No capture (stall): N_flat, step and out_* all hold. No step is skipped or duplicated.
- Output handshake:
  - A transfer occurs when out_valid && out_ready. out_valid drops after a transfer unless a new capture happens in the same cycle.
  - out_data is stable while out_valid && !out_ready.
- DRAIN: wait until out_valid==0 or a transfer occurs this cycle, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. N_flat returns to 0 on entering IDLE.
- start in any state other than IDLE is ignored. Operand inputs may change freely after an accepted start.
- Latency: start at cycle T, step 0 on N_flat at T+1, first out_valid at T+2 (no stall). Sustained rate is one step per cycle while out_ready=1.
- Sequence length N with no backpressure: done at T+N+2. For num_steps=0: busy=1 and done=1 at T+1, and out_valid never asserts.

Optional Feature:
- Macro SEL_SEQ_CLAMP_EN.
- Defined: lane addresses saturate instead of wrapping. Compute the address at full width; if it is greater than SIZE-1, use SIZE-1. The running base also saturates at SIZE-1.
- Undefined: modulo-SIZE wrap exactly as specified in Behaviour.

Test Plan:
- SIZE=16, K=4, base=2, stride=3, num_steps=3, out_ready=1 -> N_flat lanes {2,3,4,5}, {5,6,7,8}, {8,9,10,11} on consecutive cycles; out_step 0,1,2; out_last only on step 2; done pulse at T+5.
- base=14, stride=1, num_steps=2, no clamp -> lanes {14,15,0,1} then {15,0,1,2}. Same stimulus with SEL_SEQ_CLAMP_EN -> {14,15,15,15} then {15,15,15,15}.
- Backpressure: num_steps=3, out_ready low for 3 cycles after the first out_valid -> out_data/out_step=0 held stable, N_flat holds the step-1 addresses, then steps 1 and 2 delivered in order with none lost or duplicated; done follows acceptance of step 2.
- num_steps=0 -> busy=1 and done=1 at T+1, no out_valid, IDLE at T+2. A start pulse during RUN is ignored, and the operands latched at the original start are preserved.
- rst_n asserted mid-RUN with out_valid=1 -> all outputs 0 immediately (asynchronously). After release, a new start of base=0, stride=1, num_steps=1 yields lanes {0,1,2,3} and a single output with out_last=1.
